// File: rtl/axis_chk_pkg.sv
// Shared types and defaults for the inline AXI4-Stream sequence checker.
package axis_chk_pkg;

    localparam int unsigned DATA_BYTES_DEF = 64;
    localparam int unsigned EXPECT_LEN_DEF = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } chk_state_t;

    typedef struct packed {
        logic seq;
        logic pad;
        logic len;
    } err_vec_t;

    // Number of distinct errors raised by one beat (0..3).
    function automatic logic [1:0] err_weight(input err_vec_t e);
        return 2'(e.seq) + 2'(e.pad) + 2'(e.len);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow entry, registered ready.
module axis_skid_buffer
    import axis_chk_pkg::*;
#(
    parameter int unsigned WIDTH = 8 * DATA_BYTES_DEF + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_payload,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_payload,
    output logic             m_valid,
    input  logic             m_ready
);

    logic             skid_valid;
    logic             skid_valid_nxt;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             out_free;

    assign accept   = s_valid && s_ready;
    assign out_free = m_ready || !m_valid;

    // Overflow entry empties whenever the output stage can take a beat.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (out_free) begin
            skid_valid_nxt = 1'b0;
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_payload  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            skid_valid <= skid_valid_nxt;
            s_ready    <= !skid_valid_nxt;
            if (out_free) begin
                if (skid_valid) begin
                    m_payload <= skid_data;
                    m_valid   <= 1'b1;
                end else begin
                    m_valid <= accept;
                    if (accept) begin
                        m_payload <= s_payload;
                    end
                end
            end else if (accept) begin
                skid_data <= s_payload;
            end
        end
    end

endmodule

// File: rtl/axis_seq_checker.sv
// Inline AXI4-Stream checker: forwards beats through a skid buffer while checking
// per-packet sequence numbers, zero padding and packet length.
module axis_seq_checker
    import axis_chk_pkg::*;
#(
    parameter int unsigned DATA_BYTES = DATA_BYTES_DEF,
    parameter int unsigned EXPECT_LEN = EXPECT_LEN_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic                    clear,
    output logic [31:0]             pkt_count,
    output logic [15:0]             err_count,
    output logic [15:0]             last_len,
    output logic                    seq_err,
    output logic                    pad_err,
    output logic                    len_err
);

    localparam int unsigned DW = 8 * DATA_BYTES;

    logic [DW:0] m_payload;
    logic        accept;

    axis_skid_buffer #(
        .WIDTH (DW + 1)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_payload ({s_axis_tlast, s_axis_tdata}),
        .s_valid   (s_axis_tvalid),
        .s_ready   (s_axis_tready),
        .m_payload (m_payload),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready)
    );

    assign {m_axis_tlast, m_axis_tdata} = m_payload;
    assign accept = s_axis_tvalid && s_axis_tready;

    chk_state_t  state, state_nxt;
    logic [7:0]  exp_seq, exp_seq_nxt;
    logic [15:0] beat_cnt, beat_cnt_nxt, beat_inc;
    logic [31:0] pkt_base, pkt_nxt;
    logic [15:0] err_base, err_nxt, last_len_nxt;
    logic [16:0] err_sum;
    logic        seq_nxt, pad_nxt, len_nxt;
    err_vec_t    errs;

    // Checker next-state: clear zeroes status first, then this beat's errors apply.
    always_comb begin
        state_nxt    = state;
        exp_seq_nxt  = exp_seq;
        beat_cnt_nxt = beat_cnt;
        last_len_nxt = last_len;
        errs         = '0;
        beat_inc     = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
        pkt_base     = clear ? 32'd0 : pkt_count;
        err_base     = clear ? 16'd0 : err_count;
        pkt_nxt      = pkt_base;

        if (accept) begin
            errs.seq = (s_axis_tdata[7:0] != exp_seq);
            errs.pad = |s_axis_tdata[DW-1:8];
            if (s_axis_tlast) begin
                errs.len     = (beat_inc != 16'(EXPECT_LEN));
                last_len_nxt = beat_inc;
                pkt_nxt      = pkt_base + 32'd1;
                exp_seq_nxt  = 8'd0;
                beat_cnt_nxt = 16'd0;
                state_nxt    = IDLE;
            end else begin
                exp_seq_nxt  = errs.seq ? s_axis_tdata[7:0] + 8'd1 : exp_seq + 8'd1;
                beat_cnt_nxt = beat_inc;
                state_nxt    = IN_PKT;
            end
        end

        err_sum = 17'(err_base) + 17'(err_weight(errs));
        err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        seq_nxt = (seq_err && !clear) || errs.seq;
        pad_nxt = (pad_err && !clear) || errs.pad;
        len_nxt = (len_err && !clear) || errs.len;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            exp_seq   <= 8'd0;
            beat_cnt  <= 16'd0;
            pkt_count <= 32'd0;
            err_count <= 16'd0;
            last_len  <= 16'd0;
            seq_err   <= 1'b0;
            pad_err   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_seq   <= exp_seq_nxt;
            beat_cnt  <= beat_cnt_nxt;
            pkt_count <= pkt_nxt;
            err_count <= err_nxt;
            last_len  <= last_len_nxt;
            seq_err   <= seq_nxt;
            pad_err   <= pad_nxt;
            len_err   <= len_nxt;
        end
    end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Scoreboard bench for axis_seq_checker: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_axis_seq_checker;

    localparam int unsigned DB   = 64;
    localparam int unsigned DW   = 8 * DB;
    localparam int unsigned ELEN = 8;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          clear   = 1'b0;
    logic [31:0]   pkt_count;
    logic [15:0]   err_count;
    logic [15:0]   last_len;
    logic          seq_err, pad_err, len_err;

    axis_seq_checker #(
        .DATA_BYTES (DB),
        .EXPECT_LEN (ELEN)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .clear         (clear),
        .pkt_count     (pkt_count),
        .err_count     (err_count),
        .last_len      (last_len),
        .seq_err       (seq_err),
        .pad_err       (pad_err),
        .len_err       (len_err)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: what the status outputs should read, derived per beat.
    int unsigned md_pkt = 0;
    int          md_err = 0;
    int          md_last_len = 0;
    int          md_seqf = 0, md_padf = 0, md_lenf = 0;
    int          md_exp_seq = 0;
    int          md_beats = 0;
    logic [DW:0] exp_q[$];
    int          out_seen = 0;
    int          stat_req = 0;
    int          stat_done = 0;

    task automatic model_reset();
        md_pkt = 0; md_err = 0; md_last_len = 0;
        md_seqf = 0; md_padf = 0; md_lenf = 0;
        md_exp_seq = 0; md_beats = 0;
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input logic l);
        int n = 0;
        int b0 = int'(d[7:0]);
        if (b0 != md_exp_seq) begin
            md_seqf = 1; n++;
            md_exp_seq = (b0 + 1) % 256;
        end else begin
            md_exp_seq = (md_exp_seq + 1) % 256;
        end
        if (d[DW-1:8] != '0) begin
            md_padf = 1; n++;
        end
        md_beats = (md_beats + 1 > 65535) ? 65535 : md_beats + 1;
        if (l) begin
            md_last_len = md_beats;
            if (md_beats != ELEN) begin
                md_lenf = 1; n++;
            end
            md_pkt = md_pkt + 1;
            md_beats = 0;
            md_exp_seq = 0;
        end
        md_err = (md_err + n > 65535) ? 65535 : md_err + n;
    endtask

    // Monitor: feeds the model on accepts, pops the scoreboard on output handshakes.
    always @(posedge aclk) begin
        logic [DW:0] e;
        if (!aresetn) begin
            model_reset();
            exp_q.delete();
        end else begin
            if (clear) begin
                md_pkt = 0; md_err = 0;
                md_seqf = 0; md_padf = 0; md_lenf = 0;
                stat_req++;
            end
            if (s_valid && s_ready) begin
                model_beat(s_data, s_last);
                exp_q.push_back({s_last, s_data});
                stat_req++;
            end
            if (m_valid && m_ready) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_seen), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_byte0", 64'(m_data[7:0]), 64'(e[7:0]));
                    chk("out_last", 64'(m_last), 64'(e[DW]));
                    chk("out_data_equal", 64'(m_data == e[DW-1:0]), 64'd1);
                end
            end
        end
    end

    // Status comparison, one cycle after each accept or clear.
    always @(negedge aclk) begin
        if (stat_done != stat_req) begin
            stat_done = stat_req;
            if (aresetn) begin
                chk("pkt_count", 64'(pkt_count), 64'(md_pkt));
                chk("err_count", 64'(err_count), 64'(md_err));
                chk("last_len", 64'(last_len), 64'(md_last_len));
                chk("seq_err", 64'(seq_err), 64'(md_seqf));
                chk("pad_err", 64'(pad_err), 64'(md_padf));
                chk("len_err", 64'(len_err), 64'(md_lenf));
            end
        end
    end

    // Downstream ready: 0 always high, 1 two-low/six-high, 2 random.
    int rmode = 0;
    int phase = 0;
    always @(negedge aclk) begin
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = (phase % 8) >= 2;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        phase++;
    end

    function automatic logic [DW-1:0] mk(input int seq, input int padb);
        logic [DW-1:0] d = '0;
        d[7:0] = 8'(seq);
        if (padb > 0) d[padb*8 +: 8] = 8'hFF;
        return d;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic clr, output int cyc);
        s_data = d; s_last = l; s_valid = 1'b1; clear = clr;
        cyc = 0;
        while (!s_ready && cyc < 200) begin
            @(negedge aclk);
            cyc++;
        end
        if (!s_ready) chk("accept_timeout", 64'(cyc), 64'd0);
        @(negedge aclk);
        cyc++;
        s_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int base, input int skip_at,
                            input int pad_at, input int padb, output int cycles);
        int c;
        int seq;
        cycles = 0;
        for (int i = 0; i < len; i++) begin
            seq = base + i + ((skip_at >= 0 && i >= skip_at) ? 1 : 0);
            send_beat(mk(seq, (i == pad_at) ? padb : 0), i == len - 1, 1'b0, c);
            cycles += c;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        @(negedge aclk);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge aclk);
            g++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(negedge aclk);
    endtask

    initial begin
        int cyc, c, o0, len, base, skip, pad;

        repeat (2) @(negedge aclk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data_zero", 64'(m_data == '0), 64'd1);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Clean 8-beat packet at full rate.
        rmode = 0;
        @(negedge aclk);
        send_pkt(8, 0, -1, -1, 0, cyc);
        chk("t1_cycles", 64'(cyc), 64'd8);
        wait_drain();
        chk("t1_pkt", 64'(pkt_count), 64'd1);
        chk("t1_last_len", 64'(last_len), 64'd8);
        chk("t1_err", 64'(err_count), 64'd0);
        chk("t1_out_seen", 64'(out_seen), 64'd8);

        // Skipped sequence number at beat 2, then resync.
        do_clear();
        for (int i = 0; i < 8; i++) begin
            send_beat(mk((i < 2) ? i : i + 1, 0), i == 7, 1'b0, c);
            if (i == 1) chk("t2_seq_before", 64'(seq_err), 64'd0);
            if (i == 2) chk("t2_seq_at3", 64'(seq_err), 64'd1);
        end
        wait_drain();
        chk("t2_err", 64'(err_count), 64'd1);
        chk("t2_pkt", 64'(pkt_count), 64'd1);

        // Short packet, then a clean one.
        do_clear();
        send_pkt(5, 0, -1, -1, 0, cyc);
        wait_drain();
        chk("t3_len_err", 64'(len_err), 64'd1);
        chk("t3_last_len", 64'(last_len), 64'd5);
        chk("t3_pkt", 64'(pkt_count), 64'd1);
        send_pkt(8, 0, -1, -1, 0, cyc);
        wait_drain();
        chk("t3_err_after", 64'(err_count), 64'd1);
        chk("t3_last_len8", 64'(last_len), 64'd8);

        // Pad error on byte 63 of beat 2; then clear together with a bad beat.
        do_clear();
        send_pkt(8, 0, -1, 2, 63, cyc);
        wait_drain();
        chk("t4_pad", 64'(pad_err), 64'd1);
        chk("t4_err", 64'(err_count), 64'd1);
        chk("t4_seq", 64'(seq_err), 64'd0);
        send_beat(mk(5, 0), 1'b0, 1'b1, c);
        chk("t4_clr_err", 64'(err_count), 64'd1);
        chk("t4_clr_seq", 64'(seq_err), 64'd1);
        chk("t4_clr_pad", 64'(pad_err), 64'd0);
        for (int i = 1; i < 8; i++) send_beat(mk(5 + i, 0), i == 7, 1'b0, c);
        wait_drain();
        chk("t4_final_err", 64'(err_count), 64'd1);

        // Back-to-back packets with oscillating downstream ready.
        do_clear();
        rmode = 1;
        o0 = out_seen;
        for (int p = 0; p < 8; p++) send_pkt(8, 0, -1, -1, 0, cyc);
        wait_drain();
        chk("t5_delivered", 64'(out_seen - o0), 64'd64);
        chk("t5_pkt", 64'(pkt_count), 64'd8);
        chk("t5_err", 64'(err_count), 64'd0);

        // Reset in the middle of a packet.
        rmode = 0;
        do_clear();
        for (int i = 0; i < 3; i++) send_beat(mk(i, 0), 1'b0, 1'b0, c);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("t6_s_ready", 64'(s_ready), 64'd0);
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_m_last", 64'(m_last), 64'd0);
        chk("t6_m_data_zero", 64'(m_data == '0), 64'd1);
        chk("t6_flags", 64'({seq_err, pad_err, len_err}), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        send_pkt(8, 0, -1, -1, 0, cyc);
        wait_drain();
        chk("t6_pkt", 64'(pkt_count), 64'd1);
        chk("t6_err", 64'(err_count), 64'd0);

        // Randomized packets with random errors and random backpressure.
        do_clear();
        rmode = 2;
        for (int p = 0; p < 40; p++) begin
            len  = $urandom_range(1, 12);
            base = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 0;
            skip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            pad  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            send_pkt(len, base, skip, pad, $urandom_range(1, DB - 1), cyc);
            repeat ($urandom_range(0, 2)) @(negedge aclk);
        end
        wait_drain();
        chk("rand_pkt", 64'(pkt_count), 64'(md_pkt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_seq_checker.md
# axis_seq_checker

Inline AXI4-Stream checker placed in `chip` between the master stream source and the slave stream sink. It forwards every beat unchanged through a two-entry skid buffer. On each accepted input beat it checks a per-packet sequence number in byte 0, the zero padding in bytes 1..DATA_BYTES-1, and the packet length at TLAST. It exposes packet/error counters and sticky error flags for the bench scoreboard.

## Interface
- DATA_BYTES, 64, TDATA width in bytes; TDATA is 8*DATA_BYTES bits.
- EXPECT_LEN, 8, required beats per packet, range 1..65535.
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset. Only one clock exists.
- s_axis_tdata  in  8*DATA_BYTES  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tready  out  1  input ready; driven from a register.
- m_axis_tdata  out  8*DATA_BYTES  forwarded data.
- m_axis_tvalid  out  1  forwarded valid.
- m_axis_tlast  out  1  forwarded last.
- m_axis_tready  in  1  downstream ready.
- clear  in  1  synchronous pulse; zeroes all counters and sticky flags.
- pkt_count  out  32  packets completed; wraps modulo 2^32.
- err_count  out  16  error events; saturates at 16'hFFFF.
- last_len  out  16  beat count of the most recently completed packet.
- seq_err, pad_err, len_err  out  1 each  sticky error flags.

## Operation
- **Accept.** A beat is accepted when `s_axis_tvalid && s_axis_tready`. Checking happens only on accepted beats.
- **FSM states:**
  - IDLE: `exp_seq=0`, `beat_cnt=0`.
  - IN_PKT: a packet is in progress.
- **FSM transitions:**
  - IDLE -> IN_PKT on an accepted beat with TLAST=0.
  - IDLE stays IDLE on an accepted beat with TLAST=1 (a 1-beat packet).
  - IN_PKT -> IDLE on an accepted beat with TLAST=1.
- **Sequence check.** Mismatch when `tdata[7:0] != exp_seq`. On mismatch set seq_err and resync `exp_seq` to `tdata[7:0]+1`. Otherwise `exp_seq+1`. Arithmetic is mod 256.
- **Pad check.** If any bit of `tdata[8*DATA_BYTES-1:8]` is nonzero, set pad_err.
- **Length check.** `beat_cnt` is 16 bits, saturating, and counts accepted beats including the current one. On TLAST:
  - load last_len with the count;
  - if count != EXPECT_LEN, set len_err;
  - increment pkt_count even if errors occurred;
  - return `exp_seq` and `beat_cnt` to 0.
- **Error counting.** err_count increases by the number of errors on that beat (0..3), saturating.
- **Clear.** Clear does not alter FSM, `exp_seq` or `beat_cnt`. If clear coincides with an accepted erroneous beat, clear applies first and the new error is counted (err_count=1, flag set).
- **Data path.** Forwarding is lossless and order-preserving; data, last and valid are never modified by checking.

## Timing
- **Reset values:** s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, all counters/flags 0, FSM in IDLE. s_axis_tready rises on the first clock edge after aresetn deasserts.
- **Latency:** the input-to-output path is 1 cycle (registered output). Full throughput of 1 beat/cycle is sustained while m_axis_tready=1.
- **Skid behaviour:**
  - s_axis_tready drops the cycle after the skid entry fills.
  - Both entries full: s_axis_tready=0, no beat lost.
  - Simultaneous input accept and output pop while one entry is held: occupancy is unchanged.
- **Handshake rule:** m_axis_tvalid, once asserted, holds with stable data/last until m_axis_tready.
- **Status timing:** counters, flags and last_len update on the edge that accepts the checked beat and are visible the next cycle.
- **Reset mid-packet:** buffered beats are discarded and the FSM returns to IDLE. The next beat is checked as a packet start.

## Structure
- Package `axis_chk_pkg`:
  - `chk_state_t` enum {IDLE, IN_PKT};
  - DATA_BYTES default constant;
  - `err_vec_t` packed struct {seq, pad, len}.
- Sub-module `axis_skid_buffer` (parameter WIDTH = 8*DATA_BYTES+1): holds the 2-entry registered-ready buffer.
- The checker FSM and counters live in the top module.

## Test plan
- Eight beats, byte0 = 0..7, TLAST on beat 7, m_axis_tready=1 -> pkt_count=1, last_len=8, err_count=0, output matches input, throughput 1 beat/cycle.
- byte0 sequence 0,1,3,4,5,6,7,8 with TLAST on the 8th beat -> seq_err set at the third beat, err_count=1, no further seq errors after resync, pkt_count=1.
- TLAST on the 5th beat (byte0 0..4) -> len_err=1, last_len=5, pkt_count=1. The next correct 8-beat packet starting at 0 adds no errors.
- Beat 2 carries byte 63 = 8'hFF and seq 2 -> pad_err=1 and err_count=1 only. Then clear combined with an erroneous beat -> err_count=1.
- Slave ready oscillating 2 low / 6 high with 8 packets sent back-to-back -> all 64 beats delivered in order, no drops, pkt_count=8, err_count=0.
- aresetn pulsed low after beat 3 of a packet -> all outputs at reset values. A following 0..7 packet completes clean with pkt_count=1.
